// File: rtl/fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_if
//   Bundles the two handshakes of the fetch sequencer: the instruction-cache
//   request/response bus and the decoder presentation/consume bus.
//
//   master : the fetch sequencer (drives requests and the decoder buffer)
//   slave  : the environment (icache responses and decoder consume/redirect)
//
//   ic_req / ic_addr / ic_abort      sequencer -> icache
//   ic_valid / ic_inst               icache -> sequencer
//   dec_valid / dec_pc / dec_inst    sequencer -> decoder
//   dec_accept / dec_redirect(_pc)   decoder -> sequencer
// ---------------------------------------------------------------------------
interface fetch_ctrl_if;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_abort;
    logic        ic_valid;
    logic [31:0] ic_inst;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [31:0] dec_inst;
    logic        dec_accept;
    logic        dec_redirect;
    logic [31:0] dec_redirect_pc;

    modport master (
        output ic_req, ic_addr, ic_abort,
        input  ic_valid, ic_inst,
        output dec_valid, dec_pc, dec_inst,
        input  dec_accept, dec_redirect, dec_redirect_pc
    );

    modport slave (
        input  ic_req, ic_addr, ic_abort,
        output ic_valid, ic_inst,
        input  dec_valid, dec_pc, dec_inst,
        output dec_accept, dec_redirect, dec_redirect_pc
    );
endinterface

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//   Instruction-fetch sequencer. Owns the PC, keeps at most one icache
//   request outstanding, buffers one returned instruction for the decoder,
//   applies decoder redirects and ROB flushes, and stops on ROB halt.
//
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   i_rdy          global ready; low freezes all state and outputs
//   bus            fetch_ctrl_if.master (icache + decoder handshakes)
//   i_rob_flush    ROB misprediction flush, with i_rob_flush_pc
//   i_rob_halt     exit committed; enter HALT until reset
//   o_fetch_cnt    number of instructions consumed by the decoder
//   o_halted       high while in HALT
// ---------------------------------------------------------------------------
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_rdy,
    fetch_ctrl_if.master        bus,
    input  logic                i_rob_flush,
    input  logic [31:0]         i_rob_flush_pc,
    input  logic                i_rob_halt,
    output logic [31:0]         o_fetch_cnt,
    output logic                o_halted
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_HALT
    } state_t;

    state_t      r_state,     w_state;
    logic [31:0] r_pc,        w_pc;
    logic        r_ic_req,    w_ic_req;
    logic [31:0] r_ic_addr,   w_ic_addr;
    logic        r_ic_abort,  w_ic_abort;
    logic        r_dec_valid, w_dec_valid;
    logic [31:0] r_dec_pc,    w_dec_pc;
    logic [31:0] r_dec_inst,  w_dec_inst;
    logic [31:0] r_fetch_cnt, w_fetch_cnt;
    logic        r_halted,    w_halted;

    logic        w_accept;
    logic [31:0] w_next_pc;
    logic [31:0] w_flush_pc;

    // A consume only counts while an instruction is actually buffered.
    assign w_accept   = r_dec_valid & bus.dec_accept;
    assign w_next_pc  = bus.dec_redirect ? {bus.dec_redirect_pc[31:2], 2'b00}
                                         : r_pc + 32'd4;
    assign w_flush_pc = {i_rob_flush_pc[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_ic_req    <= 1'b0;
            r_ic_addr   <= RESET_PC;
            r_ic_abort  <= 1'b0;
            r_dec_valid <= 1'b0;
            r_dec_pc    <= 32'h0;
            r_dec_inst  <= 32'h0;
            r_fetch_cnt <= 32'h0;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_pc        <= w_pc;
            r_ic_req    <= w_ic_req;
            r_ic_addr   <= w_ic_addr;
            r_ic_abort  <= w_ic_abort;
            r_dec_valid <= w_dec_valid;
            r_dec_pc    <= w_dec_pc;
            r_dec_inst  <= w_dec_inst;
            r_fetch_cnt <= w_fetch_cnt;
            r_halted    <= w_halted;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_pc        = r_pc;
        w_ic_req    = r_ic_req;
        w_ic_addr   = r_ic_addr;
        w_ic_abort  = r_ic_abort;
        w_dec_valid = r_dec_valid;
        w_dec_pc    = r_dec_pc;
        w_dec_inst  = r_dec_inst;
        w_fetch_cnt = r_fetch_cnt;
        w_halted    = r_halted;

        if (i_rdy) begin
            // Abort is a single-cycle pulse: cleared on every advancing cycle.
            w_ic_abort = 1'b0;

            if (r_state != S_HALT && i_rob_halt) begin
                w_ic_abort  = (r_state == S_REQ);
                w_ic_req    = 1'b0;
                w_dec_valid = 1'b0;
                w_halted    = 1'b1;
                w_state     = S_HALT;
            end else if (r_state != S_HALT && i_rob_flush) begin
                w_pc        = w_flush_pc;
                w_dec_valid = 1'b0;
                if (w_accept) begin
                    w_fetch_cnt = r_fetch_cnt + 32'd1;
                end
                if (r_state == S_REQ) begin
                    // Drop the outstanding request this cycle; IDLE then
                    // issues the new one on the following cycle.
                    w_ic_abort = 1'b1;
                    w_ic_req   = 1'b0;
                    w_state    = S_IDLE;
                end else begin
                    w_ic_req  = 1'b1;
                    w_ic_addr = w_flush_pc;
                    w_state   = S_REQ;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        w_ic_req  = 1'b1;
                        w_ic_addr = {r_pc[31:2], 2'b00};
                        w_state   = S_REQ;
                    end
                    S_REQ: begin
                        if (bus.ic_valid) begin
                            w_dec_inst  = bus.ic_inst;
                            w_dec_pc    = r_pc;
                            w_dec_valid = 1'b1;
                            w_ic_req    = 1'b0;
                            w_state     = S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (w_accept) begin
                            w_dec_valid = 1'b0;
                            w_fetch_cnt = r_fetch_cnt + 32'd1;
                            w_pc        = w_next_pc;
                            w_ic_req    = 1'b1;
                            w_ic_addr   = {w_next_pc[31:2], 2'b00};
                            w_state     = S_REQ;
                        end
                    end
                    S_HALT: begin
                        w_state = S_HALT;
                    end
                    default: begin
                        w_state = S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.ic_req    = r_ic_req;
    assign bus.ic_addr   = r_ic_addr;
    assign bus.ic_abort  = r_ic_abort;
    assign bus.dec_valid = r_dec_valid;
    assign bus.dec_pc    = r_dec_pc;
    assign bus.dec_inst  = r_dec_inst;
    assign o_fetch_cnt   = r_fetch_cnt;
    assign o_halted      = r_halted;

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
//   Directed bench for fetch_ctrl with RESET_PC = 0. The bench plays both the
//   instruction cache and the decoder through the interface slave side.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic        rob_flush;
    logic [31:0] rob_flush_pc;
    logic        rob_halt;
    logic [31:0] fetch_cnt;
    logic        halted;

    int n_pass;
    int n_total;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_rdy          (rdy),
        .bus            (bus.master),
        .i_rob_flush    (rob_flush),
        .i_rob_flush_pc (rob_flush_pc),
        .i_rob_halt     (rob_halt),
        .o_fetch_cnt    (fetch_cnt),
        .o_halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) until ic_req is high; ok=0 when the bound expires.
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.ic_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic respond(input logic [31:0] inst);
        bus.ic_valid = 1'b1;
        bus.ic_inst  = inst;
        tick();
        bus.ic_valid = 1'b0;
        bus.ic_inst  = 32'h0;
    endtask

    task automatic accept(input logic redir, input logic [31:0] target);
        bus.dec_accept      = 1'b1;
        bus.dec_redirect    = redir;
        bus.dec_redirect_pc = target;
        tick();
        bus.dec_accept      = 1'b0;
        bus.dec_redirect    = 1'b0;
        bus.dec_redirect_pc = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_total++; if (bus.ic_req !== 1'b0) $display("FAIL reset_ic_req: got %b want 0", bus.ic_req); else n_pass++;
        n_total++; if (bus.ic_addr !== 32'h0) $display("FAIL reset_ic_addr: got %h want 00000000", bus.ic_addr); else n_pass++;
        n_total++; if (bus.dec_valid !== 1'b0 || bus.ic_abort !== 1'b0) $display("FAIL reset_valid_abort: got %b%b want 00", bus.dec_valid, bus.ic_abort); else n_pass++;
        n_total++; if (fetch_cnt !== 32'h0 || halted !== 1'b0) $display("FAIL reset_cnt_halted: got %h/%b want 0/0", fetch_cnt, halted); else n_pass++;
        tick();
        rst_n = 1'b1;
    endtask

    // Three sequential fetches with a 2-cycle icache and an immediate consume.
    task automatic test_sequential();
        bit ok;
        for (int i = 0; i < 3; i++) begin
            wait_req(ok);
            n_total++; if (!ok) $display("FAIL seq_req_timeout[%0d]: got no ic_req want ic_req", i); else n_pass++;
            n_total++; if (bus.ic_addr !== 32'(i * 4)) $display("FAIL seq_ic_addr[%0d]: got %h want %h", i, bus.ic_addr, 32'(i * 4)); else n_pass++;
            tick();
            respond(32'h00000013);
            n_total++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'(i * 4) || bus.dec_inst !== 32'h00000013)
                $display("FAIL seq_dec[%0d]: got v=%b pc=%h inst=%h want v=1 pc=%h inst=00000013", i, bus.dec_valid, bus.dec_pc, bus.dec_inst, 32'(i * 4));
            else n_pass++;
            accept(1'b0, 32'h0);
        end
        n_total++; if (fetch_cnt !== 32'd3) $display("FAIL seq_fetch_cnt: got %0d want 3", fetch_cnt); else n_pass++;
        n_total++; if (bus.ic_req !== 1'b1 || bus.ic_addr !== 32'hC) $display("FAIL seq_next_req: got req=%b addr=%h want req=1 addr=0000000c", bus.ic_req, bus.ic_addr); else n_pass++;
    endtask

    // In REQ at 0xC on entry.
    task automatic test_redirect();
        respond(32'h0000000C);
        accept(1'b0, 32'h0);
        respond(32'h00000010);
        n_total++; if (bus.dec_pc !== 32'h10) $display("FAIL redir_hold_pc: got %h want 00000010", bus.dec_pc); else n_pass++;
        // Redirect without accept must not move anything.
        bus.dec_redirect    = 1'b1;
        bus.dec_redirect_pc = 32'h00000777;
        tick();
        bus.dec_redirect    = 1'b0;
        n_total++; if (bus.dec_valid !== 1'b1 || bus.ic_req !== 1'b0 || fetch_cnt !== 32'd4)
            $display("FAIL redir_no_accept: got v=%b req=%b cnt=%0d want v=1 req=0 cnt=4", bus.dec_valid, bus.ic_req, fetch_cnt);
        else n_pass++;
        accept(1'b1, 32'h00000103);
        n_total++; if (bus.ic_req !== 1'b1 || bus.ic_addr !== 32'h100 || fetch_cnt !== 32'd5)
            $display("FAIL redir_target: got req=%b addr=%h cnt=%0d want req=1 addr=00000100 cnt=5", bus.ic_req, bus.ic_addr, fetch_cnt);
        else n_pass++;
        respond(32'hDEADBEEF);
        n_total++; if (bus.dec_pc !== 32'h100 || bus.dec_inst !== 32'hDEADBEEF) $display("FAIL redir_dec: got pc=%h inst=%h want 00000100/deadbeef", bus.dec_pc, bus.dec_inst); else n_pass++;
        // ic_valid outside REQ is ignored.
        respond(32'h55555555);
        n_total++; if (bus.dec_inst !== 32'hDEADBEEF) $display("FAIL ivalid_in_hold: got inst=%h want deadbeef", bus.dec_inst); else n_pass++;
        accept(1'b0, 32'h0);
        n_total++; if (bus.ic_addr !== 32'h104 || fetch_cnt !== 32'd6) $display("FAIL redir_seq_after: got addr=%h cnt=%0d want 00000104/6", bus.ic_addr, fetch_cnt); else n_pass++;
    endtask

    // In REQ at 0x104 on entry.
    task automatic test_flush();
        respond(32'h00000104);
        // Flush out of HOLD: new request issued right away, no abort.
        rob_flush = 1'b1; rob_flush_pc = 32'h00000022;
        tick();
        rob_flush = 1'b0;
        n_total++; if (bus.ic_req !== 1'b1 || bus.ic_addr !== 32'h20 || bus.dec_valid !== 1'b0 || bus.ic_abort !== 1'b0 || fetch_cnt !== 32'd6)
            $display("FAIL flush_hold: got req=%b addr=%h v=%b ab=%b cnt=%0d want 1/00000020/0/0/6", bus.ic_req, bus.ic_addr, bus.dec_valid, bus.ic_abort, fetch_cnt);
        else n_pass++;
        // Flush in REQ coincident with a response.
        rob_flush = 1'b1; rob_flush_pc = 32'h00000200;
        bus.ic_valid = 1'b1; bus.ic_inst = 32'h11111111;
        tick();
        rob_flush = 1'b0; bus.ic_valid = 1'b0;
        n_total++; if (bus.ic_abort !== 1'b1 || bus.ic_req !== 1'b0 || bus.dec_valid !== 1'b0)
            $display("FAIL flush_req_abort: got ab=%b req=%b v=%b want 1/0/0", bus.ic_abort, bus.ic_req, bus.dec_valid);
        else n_pass++;
        tick();
        n_total++; if (bus.ic_abort !== 1'b0 || bus.ic_req !== 1'b1 || bus.ic_addr !== 32'h200 || bus.dec_valid !== 1'b0)
            $display("FAIL flush_req_restart: got ab=%b req=%b addr=%h v=%b want 0/1/00000200/0", bus.ic_abort, bus.ic_req, bus.ic_addr, bus.dec_valid);
        else n_pass++;
        respond(32'h22222222);
        n_total++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'h200 || bus.dec_inst !== 32'h22222222)
            $display("FAIL flush_new_inst: got v=%b pc=%h inst=%h want 1/00000200/22222222", bus.dec_valid, bus.dec_pc, bus.dec_inst);
        else n_pass++;
        // Flush with coincident accept+redirect: count increments, flush target wins.
        rob_flush = 1'b1; rob_flush_pc = 32'h00000300;
        bus.dec_accept = 1'b1; bus.dec_redirect = 1'b1; bus.dec_redirect_pc = 32'h00000500;
        tick();
        rob_flush = 1'b0; bus.dec_accept = 1'b0; bus.dec_redirect = 1'b0;
        n_total++; if (bus.ic_addr !== 32'h300 || bus.ic_req !== 1'b1 || fetch_cnt !== 32'd7)
            $display("FAIL flush_with_accept: got addr=%h req=%b cnt=%0d want 00000300/1/7", bus.ic_addr, bus.ic_req, fetch_cnt);
        else n_pass++;
    endtask

    // In REQ at 0x300 on entry.
    task automatic test_rdy_stall();
        respond(32'h33333333);
        rdy = 1'b0;
        bus.dec_accept = 1'b1;
        repeat (5) tick();
        n_total++; if (bus.dec_valid !== 1'b1 || fetch_cnt !== 32'd7 || bus.ic_req !== 1'b0)
            $display("FAIL rdy_frozen: got v=%b cnt=%0d req=%b want 1/7/0", bus.dec_valid, fetch_cnt, bus.ic_req);
        else n_pass++;
        rdy = 1'b1;
        tick();
        bus.dec_accept = 1'b0;
        n_total++; if (fetch_cnt !== 32'd8 || bus.ic_addr !== 32'h304 || bus.ic_req !== 1'b1)
            $display("FAIL rdy_release: got cnt=%0d addr=%h req=%b want 8/00000304/1", fetch_cnt, bus.ic_addr, bus.ic_req);
        else n_pass++;
        tick();
        n_total++; if (fetch_cnt !== 32'd8 || bus.ic_addr !== 32'h304) $display("FAIL rdy_once: got cnt=%0d addr=%h want 8/00000304", fetch_cnt, bus.ic_addr); else n_pass++;
    endtask

    // In REQ at 0x304 on entry.
    task automatic test_wrap();
        rob_flush = 1'b1; rob_flush_pc = 32'hFFFFFFFF;
        tick();
        rob_flush = 1'b0;
        tick();
        n_total++; if (bus.ic_addr !== 32'hFFFFFFFC || bus.ic_req !== 1'b1) $display("FAIL wrap_top_req: got addr=%h req=%b want fffffffc/1", bus.ic_addr, bus.ic_req); else n_pass++;
        respond(32'h44444444);
        n_total++; if (bus.dec_pc !== 32'hFFFFFFFC) $display("FAIL wrap_top_pc: got %h want fffffffc", bus.dec_pc); else n_pass++;
        accept(1'b0, 32'h0);
        n_total++; if (bus.ic_addr !== 32'h0 || bus.ic_req !== 1'b1 || fetch_cnt !== 32'd9)
            $display("FAIL wrap_zero: got addr=%h req=%b cnt=%0d want 00000000/1/9", bus.ic_addr, bus.ic_req, fetch_cnt);
        else n_pass++;
    endtask

    // In REQ at 0x0 on entry.
    task automatic test_halt();
        int bad;
        bad = 0;
        rob_halt = 1'b1; rob_flush = 1'b1; rob_flush_pc = 32'h00000400;
        tick();
        rob_halt = 1'b0; rob_flush = 1'b0;
        n_total++; if (halted !== 1'b1 || bus.ic_req !== 1'b0 || bus.ic_abort !== 1'b1)
            $display("FAIL halt_enter: got halted=%b req=%b ab=%b want 1/0/1", halted, bus.ic_req, bus.ic_abort);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                bus.ic_valid = 1'b1; bus.ic_inst = 32'h66666666;
            end
            if (i == 8) begin
                rob_flush = 1'b1; rob_flush_pc = 32'h00000600;
            end
            tick();
            bus.ic_valid = 1'b0; rob_flush = 1'b0;
            if (bus.ic_req !== 1'b0 || bus.ic_abort !== 1'b0 || bus.dec_valid !== 1'b0 || halted !== 1'b1) bad++;
        end
        n_total++; if (bad != 0) $display("FAIL halt_quiet: got %0d bad cycles want 0", bad); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if (bus.ic_addr !== 32'h0 || halted !== 1'b0 || fetch_cnt !== 32'h0)
            $display("FAIL halt_reset: got addr=%h halted=%b cnt=%0d want 00000000/0/0", bus.ic_addr, halted, fetch_cnt);
        else n_pass++;
        tick();
        rst_n = 1'b1;
    endtask

    // Asynchronous reset in the middle of an outstanding request.
    task automatic test_reset_mid_req();
        bit ok;
        wait_req(ok);
        respond(32'h77777777);
        accept(1'b0, 32'h0);
        n_total++; if (!ok || bus.ic_req !== 1'b1 || bus.ic_addr !== 32'h4 || fetch_cnt !== 32'd1)
            $display("FAIL midreq_setup: got ok=%b req=%b addr=%h cnt=%0d want 1/1/00000004/1", ok, bus.ic_req, bus.ic_addr, fetch_cnt);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if (bus.ic_req !== 1'b0 || bus.ic_addr !== 32'h0 || fetch_cnt !== 32'h0 || bus.dec_valid !== 1'b0 || bus.ic_abort !== 1'b0)
            $display("FAIL midreq_reset: got req=%b addr=%h cnt=%0d v=%b ab=%b want 0/00000000/0/0/0", bus.ic_req, bus.ic_addr, fetch_cnt, bus.dec_valid, bus.ic_abort);
        else n_pass++;
        n_total++; if (bus.dec_pc !== 32'h0 || bus.dec_inst !== 32'h0 || halted !== 1'b0)
            $display("FAIL midreq_reset_dec: got pc=%h inst=%h halted=%b want 0/0/0", bus.dec_pc, bus.dec_inst, halted);
        else n_pass++;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n = 1'b0;
        rdy = 1'b1;
        rob_flush = 1'b0;
        rob_flush_pc = 32'h0;
        rob_halt = 1'b0;
        bus.ic_valid = 1'b0;
        bus.ic_inst = 32'h0;
        bus.dec_accept = 1'b0;
        bus.dec_redirect = 1'b0;
        bus.dec_redirect_pc = 32'h0;
        tick();

        test_reset();
        test_sequential();
        test_redirect();
        test_flush();
        test_rdy_stall();
        test_wrap();
        test_halt();
        test_reset_mid_req();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
